title_loader: RTL and testbench

Upstream feeder for the title display stage. Accepts a title as a stream of 6-bit glyph codes over a valid/ready handshake and stores up to `MAX_LEN` codes. It drives the twelve 9-bit glyph-ROM base addresses consumed by the title renderer. Titles of 12 codes or fewer are shown statically; longer titles scroll left one slot every `SCROLL_FRAMES` frames with a blank gap before wrap-around. All output changes are aligned to `frame_tick`, so the display never tears mid-frame.

---
 rtl/title_loader.sv | 141 ++++++++++++++
 tb/tb_title_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/title_loader.sv
// Title loader: buffers a streamed title of glyph codes and drives twelve glyph-ROM
// base addresses, static for short titles and scrolling with a blank gap for long ones.
module title_loader #(
    parameter int MAX_LEN       = 24,
    parameter int SCROLL_FRAMES = 30,
    parameter int GAP           = 4,
    parameter int ROWS_PER_CHAR = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_start,
    input  logic       char_valid,
    input  logic [5:0] char_code,
    input  logic       char_last,
    output logic       char_ready,
    input  logic       frame_tick,
    output logic [8:0] char1,
    output logic [8:0] char2,
    output logic [8:0] char3,
    output logic [8:0] char4,
    output logic [8:0] char5,
    output logic [8:0] char6,
    output logic [8:0] char7,
    output logic [8:0] char8,
    output logic [8:0] char9,
    output logic [8:0] char10,
    output logic [8:0] char11,
    output logic [8:0] char12,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE, LOAD, STATIC, SCROLL} state_t;

    localparam int FCW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int IW  = $clog2(MAX_LEN);

    state_t           state_q, state_d;
    logic [5:0]       len_q, offset_q, len_next;
    logic [FCW-1:0]   frame_cnt_q;
    logic [5:0]       buf_q [MAX_LEN];
    logic [8:0]       slot_q [12];
    logic [6:0]       span, offset_inc;
    logic [6:0]       sum_w [12];
    logic [6:0]       wrap_w [12];
    logic [5:0]       pos_w [12];
    logic [5:0]       code_w [12];
    logic             xfer, len_full, showing;

    // Handshake: a code moves when char_valid && char_ready in the same cycle;
    // char_ready depends only on state, and a same-cycle load_start cancels the move.
    assign char_ready = (state_q == LOAD);
    assign xfer       = char_valid && char_ready && !load_start;
    assign len_full   = (len_q == 6'(MAX_LEN));
    assign len_next   = len_full ? len_q : len_q + 6'd1;
    assign span       = {1'b0, len_q} + 7'(GAP);
    assign offset_inc = {1'b0, offset_q} + 7'd1;
    assign showing    = (state_q == STATIC) || (state_q == SCROLL);
    assign dbg_state  = state_q;

    always_comb begin
        state_d = state_q;
        if (load_start)
            state_d = LOAD;
        else if (xfer && char_last)
            state_d = (len_next <= 6'd12) ? STATIC : SCROLL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= 6'd0;
            offset_q    <= 6'd0;
            frame_cnt_q <= '0;
        end else if (load_start) begin
            len_q       <= 6'd0;
            offset_q    <= 6'd0;
            frame_cnt_q <= '0;
        end else begin
            if (xfer && !len_full)
                len_q <= len_q + 6'd1;
            if (state_q == SCROLL && frame_tick) begin
                if (frame_cnt_q == FCW'(SCROLL_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    offset_q    <= (offset_inc == span) ? 6'd0 : offset_inc[5:0];
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    // Codes beyond MAX_LEN are accepted but never stored.
    always_ff @(posedge clk) begin
        if (xfer && !len_full)
            buf_q[IW'(len_q)] <= char_code;
    end

    // offset < len+GAP and i < 12 < len+GAP while scrolling, so one subtract wraps.
    always_comb begin
        for (int i = 0; i < 12; i++) begin
            sum_w[i]  = {1'b0, offset_q} + 7'(i);
            wrap_w[i] = (sum_w[i] >= span) ? sum_w[i] - span : sum_w[i];
            pos_w[i]  = 6'd0;
            if (state_q == STATIC)
                pos_w[i] = 6'(i);
            else if (state_q == SCROLL)
                pos_w[i] = wrap_w[i][5:0];
            code_w[i] = (showing && pos_w[i] < len_q) ? buf_q[IW'(pos_w[i])] : 6'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++)
                slot_q[i] <= 9'd0;
        end else if (frame_tick) begin
            for (int i = 0; i < 12; i++)
                slot_q[i] <= {3'b000, code_w[i]} * 9'(ROWS_PER_CHAR);
        end
    end

    assign char1  = slot_q[0];
    assign char2  = slot_q[1];
    assign char3  = slot_q[2];
    assign char4  = slot_q[3];
    assign char5  = slot_q[4];
    assign char6  = slot_q[5];
    assign char7  = slot_q[6];
    assign char8  = slot_q[7];
    assign char9  = slot_q[8];
    assign char10 = slot_q[9];
    assign char11 = slot_q[10];
    assign char12 = slot_q[11];

endmodule

// File: tb/tb_title_loader.sv
// Bench for title_loader: table vectors, directed scroll/overflow/restart sequences
// and random traffic against a frame-count based reference model.
module tb_title_loader;
    localparam int MAX_LEN = 24;
    localparam int SF      = 2;
    localparam int GAP     = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       load_start = 1'b0, char_valid = 1'b0, char_last = 1'b0, frame_tick = 1'b0;
    logic [5:0] char_code = 6'd0;
    logic       char_ready;
    logic [8:0] c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12;
    logic [1:0] dbg_state;
    logic [107:0] dut_win;

    assign dut_win = {c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12};

    title_loader #(.MAX_LEN(MAX_LEN), .SCROLL_FRAMES(SF), .GAP(GAP), .ROWS_PER_CHAR(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .char_valid(char_valid),
        .char_code(char_code), .char_last(char_last), .char_ready(char_ready),
        .frame_tick(frame_tick),
        .char1(c1), .char2(c2), .char3(c3), .char4(c4), .char5(c5), .char6(c6),
        .char7(c7), .char8(c8), .char9(c9), .char10(c10), .char11(c11), .char12(c12),
        .dbg_state(dbg_state)
    );

    // reference model: title as a list, scroll offset derived from ticks seen
    typedef enum {M_IDLE, M_LOAD, M_STATIC, M_SCROLL} mode_t;
    mode_t      m_mode = M_IDLE;
    logic [5:0] m_title[$];
    int         m_ticks = 0;
    logic [8:0] m_out[12];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_slot(input int i);
        int len, pos;
        len = m_title.size();
        if (m_mode == M_STATIC)      pos = i;
        else if (m_mode == M_SCROLL) pos = ((m_ticks / SF) % (len + GAP) + i) % (len + GAP);
        else return 9'd0;
        return (pos < len) ? {m_title[pos], 3'b000} : 9'd0;
    endfunction

    function automatic logic [107:0] m_win();
        logic [107:0] w;
        for (int i = 0; i < 12; i++) w[107 - 9*i -: 9] = m_out[i];
        return w;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_title.delete();
        m_ticks = 0;
        for (int i = 0; i < 12; i++) m_out[i] = 9'd0;
    endtask

    task automatic model_edge(input logic ls, cv, input logic [5:0] cc, input logic cl, ft);
        if (ft)
            for (int i = 0; i < 12; i++) m_out[i] = ref_slot(i);
        if (ls) begin
            m_mode = M_LOAD;
            m_title.delete();
            m_ticks = 0;
        end else if (m_mode == M_LOAD && cv) begin
            if (m_title.size() < MAX_LEN) m_title.push_back(cc);
            if (cl) m_mode = (m_title.size() <= 12) ? M_STATIC : M_SCROLL;
        end else if (m_mode == M_SCROLL && ft) begin
            m_ticks++;
        end
    endtask

    // driver: apply at negedge, model at posedge, sample 1ns later
    task automatic step(input logic ls, cv, input logic [5:0] cc, input logic cl, ft);
        load_start = ls; char_valid = cv; char_code = cc; char_last = cl; frame_tick = ft;
        @(posedge clk);
        model_edge(ls, cv, cc, cl, ft);
        #1;
        check("char_ready", char_ready, m_mode == M_LOAD);
        check("window", dut_win, m_win());
        @(negedge clk);
    endtask

    task automatic tick();
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    endtask

    task automatic idle_noise();
        step(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    typedef struct {
        logic       ls, cv;
        logic [5:0] code;
        logic       last, ft;
        logic       exp_ready;
        logic [44:0] exp_c15;
    } vec_t;

    vec_t tbl[8];
    logic [107:0] saved_win;
    logic [107:0] exp_w;

    initial begin
        model_reset();
        #1;
        check("reset_ready", char_ready, 1'b0);
        check("reset_window", dut_win, 108'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // static title via table
        tbl[0] = '{1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 45'd0};
        tbl[1] = '{1'b0, 1'b1, 6'd8,  1'b0, 1'b0, 1'b1, 45'd0};
        tbl[2] = '{1'b0, 1'b1, 6'd5,  1'b0, 1'b0, 1'b1, 45'd0};
        tbl[3] = '{1'b0, 1'b1, 6'd12, 1'b0, 1'b0, 1'b1, 45'd0};
        tbl[4] = '{1'b0, 1'b1, 6'd12, 1'b0, 1'b0, 1'b1, 45'd0};
        tbl[5] = '{1'b0, 1'b1, 6'd15, 1'b1, 1'b0, 1'b0, 45'd0};
        tbl[6] = '{1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, {9'd64, 9'd40, 9'd96, 9'd96, 9'd120}};
        tbl[7] = '{1'b0, 1'b1, 6'd33, 1'b1, 1'b1, 1'b0, {9'd64, 9'd40, 9'd96, 9'd96, 9'd120}};
        for (int k = 0; k < 8; k++) begin
            step(tbl[k].ls, tbl[k].cv, tbl[k].code, tbl[k].last, tbl[k].ft);
            check("tbl_ready", char_ready, tbl[k].exp_ready);
            check("tbl_chars", {c1, c2, c3, c4, c5}, tbl[k].exp_c15);
        end
        for (int k = 0; k < 100; k++) tick();
        check("static_hold", dut_win, {9'd64, 9'd40, 9'd96, 9'd96, 9'd120, 63'd0});

        // asynchronous reset in the middle of a load
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd7, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", char_ready, 1'b0);
        check("async_rst_window", dut_win, 108'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 6'd5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 6'd5, 1'b1, 1'b1);
        check("post_rst_idle", dbg_state, 2'd0);

        // scrolling title 1..16
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) step(1'b0, 1'b1, 6'(k), k == 16, 1'b0);
        for (int t = 1; t <= 41; t++) begin
            repeat ($urandom_range(0, 2)) idle_noise();
            tick();
            if (t == 1) begin
                for (int i = 0; i < 12; i++) exp_w[107 - 9*i -: 9] = 9'((i + 1) * 8);
                check("scroll_t1", dut_win, exp_w);
                saved_win = dut_win;
            end
            if (t == 3) begin
                check("scroll_t3_c1", c1, 9'd16);
                check("scroll_t3_c12", c12, 9'd104);
            end
            if (t == 11) check("scroll_gap_c12", c12, 9'd0);
            if (t == 33) check("scroll_off16", {c1, c2, c3, c4, c5}, {36'd0, 9'd8});
            if (t == 41) check("scroll_wrap", dut_win, saved_win);
        end

        // restart collides with a transfer during scroll
        step(1'b1, 1'b1, 6'd9, 1'b0, 1'b0);
        check("restart_ready", char_ready, 1'b1);
        tick();
        check("restart_blank", dut_win, 108'd0);
        step(1'b0, 1'b1, 6'd21, 1'b1, 1'b0);
        tick();
        check("restart_c1", c1, 9'd168);
        check("restart_c2", c2, 9'd0);
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b1);
        check("ls_tick_old", c1, 9'd168);
        tick();
        check("ls_tick_blank", dut_win, 108'd0);

        // overflow: 30 codes of 3 into a 24-deep buffer
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b1, 6'd3, k == 30, 1'b0);
            if (k < 30) check("ovf_ready", char_ready, 1'b1);
        end
        for (int t = 1; t <= 57; t++) begin
            tick();
            if (t == 1) saved_win = dut_win;
            if (t == 25) check("ovf_off12_c12", c12, 9'd24);
            if (t == 27) check("ovf_off13_c12", c12, 9'd0);
            if (t == 49) check("ovf_off24", {c1, c5}, {9'd0, 9'd24});
            if (t == 57) check("ovf_wrap", dut_win, saved_win);
        end

        // random traffic
        for (int k = 0; k < 2500; k++)
            step(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 9) < 7),
                 6'($urandom_range(0, 63)), 1'($urandom_range(0, 20) == 0),
                 1'($urandom_range(0, 3) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
